// File: rtl/priority_encoder_8x3_if.sv
// Request-vector / encoded-result bundle for priority_encoder_8x3.
// master drives the request side; slave (the encoder) drives the result side.
interface priority_encoder_8x3_if;
  logic       en;
  logic [7:0] in;
  logic [2:0] out;
  logic       valid;
  logic       multi;

  modport master (output en, output in, input out, input valid, input multi);
  modport slave  (input en, input in, output out, output valid, output multi);
endinterface

// File: rtl/priority_encoder_8x3.sv
// Registered 8-to-3 MSB-first priority encoder with zero and multi-hot flags.
// Optional multi-hot detection is built only when PRIORITY_ENCODER_MULTI_DETECT_EN is defined.
module priority_encoder_8x3 (
  input  logic                 clk,
  input  logic                 rst,
  priority_encoder_8x3_if.slave bus
);
  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 3;

  typedef struct packed {
    logic [OUT_W-1:0] idx;
    logic             valid;
    logic             multi;
  } result_t;

  result_t dec_c;
  result_t res_q;

  // Ascending scan so the highest set bit is the last assignment to win.
  always_comb begin
    dec_c = '0;
    for (int i = 0; i < int'(IN_W); i++) begin
      if (bus.in[i]) dec_c.idx = OUT_W'(i);
    end
    dec_c.valid = |bus.in;
`ifdef PRIORITY_ENCODER_MULTI_DETECT_EN
    // Clearing the lowest set bit leaves something iff two or more bits were set.
    dec_c.multi = |(bus.in & (bus.in - IN_W'(1)));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else if (bus.en) begin
      res_q <= dec_c;
    end
  end

  assign bus.out   = res_q.idx;
  assign bus.valid = res_q.valid;
  assign bus.multi = res_q.multi;
endmodule

// File: tb/tb_priority_encoder_8x3.sv
// Self-checking bench for priority_encoder_8x3: log2/popcount model plus literal vectors.
// Honours PRIORITY_ENCODER_MULTI_DETECT_EN for the expected multi flag.
module tb_priority_encoder_8x3;
`ifdef PRIORITY_ENCODER_MULTI_DETECT_EN
  localparam bit MULTI_ON = 1'b1;
`else
  localparam bit MULTI_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic armed = 1'b0;
  int   tests = 0;
  int   fails = 0;

  priority_encoder_8x3_if bus ();

  priority_encoder_8x3 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: floor(log2(v)) and popcount, captured like the registers.
  logic [2:0] m_out   = '0;
  logic       m_valid = 1'b0;
  logic       m_multi = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out   <= '0;
      m_valid <= 1'b0;
      m_multi <= 1'b0;
    end else if (bus.en) begin
      m_out   <= (bus.in == 8'd0) ? 3'd0 : 3'($clog2(int'(bus.in) + 1) - 1);
      m_valid <= (bus.in != 8'd0);
      m_multi <= MULTI_ON && ($countones(bus.in) >= 2);
    end
  end

  task automatic chk(input string name, input logic [2:0] eo, input logic ev, input logic em);
    tests++;
    if (bus.out !== eo || bus.valid !== ev || bus.multi !== em) begin
      fails++;
      $display("FAIL %s: got out=%0d valid=%b multi=%b, expected out=%0d valid=%b multi=%b",
               name, bus.out, bus.valid, bus.multi, eo, ev, em);
    end
  endtask

  // Continuous model comparison, away from the active edge.
  always @(negedge clk) begin
    if (armed) chk("model", m_out, m_valid, m_multi);
  end

  task automatic apply(input logic e, input logic [7:0] v);
    @(negedge clk);
    bus.en = e;
    bus.in = v;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rv_in  [12] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h02, 8'h40,
                              8'h1F, 8'hC0, 8'h05, 8'h3C, 8'h11, 8'h0C};
  logic [2:0] rv_out [12] = '{3'd5, 3'd7, 3'd3, 3'd6, 3'd1, 3'd6,
                              3'd4, 3'd7, 3'd2, 3'd5, 3'd4, 3'd3};
  logic       rv_mul [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    bus.en = 1'b0;
    bus.in = 8'h00;
    @(posedge clk);
    #1;
    armed = 1'b1;
    chk("reset_state", 3'd0, 1'b0, 1'b0);

    // Load a non-zero result, then assert reset asynchronously mid-cycle.
    @(negedge clk);
    rst = 1'b0;
    apply(1'b1, 8'hFF);
    chk("pre_reset_ff", 3'd7, 1'b1, MULTI_ON);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int j = 0; j < 8; j++) begin
      apply(1'b1, 8'(1 << j));
      chk($sformatf("onehot_%0d", j), 3'(j), 1'b1, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        apply(1'b1, 8'((1 << i) | (1 << j)));
        chk($sformatf("twohot_%0d_%0d", i, j), 3'(j), 1'b1, MULTI_ON);
      end
    end

    apply(1'b1, 8'h00);
    chk("zero_in", 3'd0, 1'b0, 1'b0);
    apply(1'b1, 8'h01);
    chk("bit0_in", 3'd0, 1'b1, 1'b0);

    for (int k = 0; k < 12; k++) begin
      apply(1'b1, rv_in[k]);
      chk($sformatf("vec_%02h", rv_in[k]), rv_out[k], 1'b1, MULTI_ON & rv_mul[k]);
    end

    // Extra random vectors, checked by the model process only.
    for (int k = 0; k < 16; k++) begin
      apply(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    apply(1'b1, 8'h10);
    chk("hold_capture", 3'd4, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 8'h80);
      chk($sformatf("hold_%0d", k), 3'd4, 1'b1, 1'b0);
    end
    apply(1'b1, 8'h80);
    chk("hold_release", 3'd7, 1'b1, 1'b0);

    // Reset coinciding with an enabled edge: reset wins.
    @(negedge clk);
    bus.en = 1'b1;
    bus.in = 8'hA5;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_wins", 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_after_reset", 3'd7, 1'b1, MULTI_ON);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
